wb_regfile: RTL and testbench

Write-back stage and architectural register file of the pipelined MIPS datapath. Sits directly downstream of the MEM/WB pipeline register. Selects the write-back value (memory load result or ALU result) and commits it to the 32×32 register file. Serves the two ID-stage read ports with same-cycle write-through bypass, and exposes the selected write-back value for EX-stage forwarding.

---
 rtl/wb_regfile_pkg.sv | 9 +
 rtl/wb_regfile_select.sv | 11 +
 rtl/wb_regfile.sv | 48 ++++
 tb/tb_wb_regfile.sv | 132 +++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths, register-zero constant and datapath typedefs
package wb_regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;
   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/wb_regfile_select.sv
// wb_select: MemToReg write-back mux, reused by the forwarding unit
module wb_select #(
   parameter int W = 32
) (
   input  logic         i_sel,
   input  logic [W-1:0] i_mem,
   input  logic [W-1:0] i_alu,
   output logic [W-1:0] o_data
);
   assign o_data = i_sel ? i_mem : i_alu;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32x32 register file with write-through bypass
module wb_regfile #(
   parameter int DATA_W   = wb_regfile_pkg::DATA_W,
   parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
   parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWrite,
   input  logic              MemToReg,
   input  logic [DATA_W-1:0] MemRes,
   input  logic [DATA_W-1:0] ALURes,
   input  logic [ADDR_W-1:0] WREG,
   input  logic [ADDR_W-1:0] RR1,
   input  logic [ADDR_W-1:0] RR2,
   input  logic [ADDR_W-1:0] DBG_ADDR,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic [DATA_W-1:0] WB_Data,
   output logic [DATA_W-1:0] DBG_DATA,
   output logic [31:0]       WB_Count
);
   import wb_regfile_pkg::*;
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [31:0]       r_count;
   logic              w_wr_en;
   wb_select #(.W(DATA_W)) u_sel (
      .i_sel  (MemToReg),
      .i_mem  (MemRes),
      .i_alu  (ALURes),
      .o_data (WB_Data)
   );
   // Gating with ~rst both drops the reset-cycle write and disables bypass
   assign w_wr_en = RegWrite & ~rst & (WREG != REG_ZERO);
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_count <= '0;
      end else if (w_wr_en) begin
         r_regs[WREG] <= WB_Data;
         r_count      <= r_count + 32'd1;
      end
   end
   assign RD1      = (RR1 == REG_ZERO) ? '0 : (w_wr_en && WREG == RR1) ? WB_Data : r_regs[RR1];
   assign RD2      = (RR2 == REG_ZERO) ? '0 : (w_wr_en && WREG == RR2) ? WB_Data : r_regs[RR2];
   assign DBG_DATA = (DBG_ADDR == REG_ZERO) ? '0 : r_regs[DBG_ADDR];
   assign WB_Count = r_count;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors for write-back select, bypass, reset and counter
module tb_wb_regfile;
   logic        clk = 0, rst = 1, RegWrite = 0, MemToReg = 0;
   logic [31:0] MemRes = 0, ALURes = 0;
   logic [4:0]  WREG = 0, RR1 = 0, RR2 = 0, DBG_ADDR = 0;
   logic [31:0] RD1, RD2, WB_Data, DBG_DATA, WB_Count;
   int n_vec = 0, n_err = 0;

   wb_regfile dut (
      .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemToReg(MemToReg),
      .MemRes(MemRes), .ALURes(ALURes), .WREG(WREG), .RR1(RR1), .RR2(RR2),
      .DBG_ADDR(DBG_ADDR), .RD1(RD1), .RD2(RD2), .WB_Data(WB_Data),
      .DBG_DATA(DBG_DATA), .WB_Count(WB_Count)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      @(negedge clk); rst = 1; RegWrite = 1; WREG = 9; ALURes = 32'h99;
      @(negedge clk); RegWrite = 0; rst = 0;
      for (int i = 0; i < 32; i++) begin
         RR1 = 5'(i); RR2 = 5'(31 - i); DBG_ADDR = 5'(i); #1;
         n_vec++;
         if (RD1 !== 0 || RD2 !== 0 || DBG_DATA !== 0) begin
            n_err++;
            $display("FAIL reset_read addr=%0d RD1=%h RD2=%h DBG=%h want 0", i, RD1, RD2, DBG_DATA);
         end
      end
      n_vec++;
      if (WB_Count !== 0) begin n_err++; $display("FAIL reset_count got %0d want 0", WB_Count); end
   endtask

   task automatic test_bypass;
      @(negedge clk); RegWrite = 1; MemToReg = 0; ALURes = 32'h1234_5678; MemRes = 32'h0BAD_0BAD;
      WREG = 5; RR1 = 5; RR2 = 4; DBG_ADDR = 5; #1;
      n_vec++;
      if (RD1 !== 32'h1234_5678) begin n_err++; $display("FAIL bypass_rd1 got %h want 12345678", RD1); end
      n_vec++;
      if (WB_Data !== 32'h1234_5678) begin n_err++; $display("FAIL wb_data_alu got %h want 12345678", WB_Data); end
      n_vec++;
      if (DBG_DATA !== 0 || RD2 !== 0) begin n_err++; $display("FAIL no_bypass DBG=%h RD2=%h want 0", DBG_DATA, RD2); end
      @(negedge clk); RegWrite = 0; #1;
      n_vec++;
      if (RD1 !== 32'h1234_5678 || DBG_DATA !== 32'h1234_5678) begin
         n_err++; $display("FAIL stored_r5 RD1=%h DBG=%h want 12345678", RD1, DBG_DATA);
      end
      n_vec++;
      if (WB_Count !== 1) begin n_err++; $display("FAIL count_after_w5 got %0d want 1", WB_Count); end
   endtask

   task automatic test_reg_zero;
      @(negedge clk); RegWrite = 1; MemToReg = 1; MemRes = 32'hDEAD_BEEF; ALURes = 32'h1;
      WREG = 0; RR1 = 0; RR2 = 0; DBG_ADDR = 0; #1;
      n_vec++;
      if (RD1 !== 0 || RD2 !== 0) begin n_err++; $display("FAIL r0_bypass RD1=%h RD2=%h want 0", RD1, RD2); end
      n_vec++;
      if (WB_Data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wb_data_mem got %h want deadbeef", WB_Data); end
      @(negedge clk); RegWrite = 0; #1;
      n_vec++;
      if (RD1 !== 0 || DBG_DATA !== 0) begin n_err++; $display("FAIL r0_stored RD1=%h DBG=%h want 0", RD1, DBG_DATA); end
      n_vec++;
      if (WB_Count !== 1) begin n_err++; $display("FAIL r0_count got %0d want 1", WB_Count); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk); RegWrite = 1; MemToReg = 0; ALURes = 32'hAAAA_AAAA; WREG = 7; RR1 = 7; RR2 = 7; DBG_ADDR = 7; #1;
      n_vec++;
      if (RD1 !== 32'hAAAA_AAAA || RD2 !== 32'hAAAA_AAAA) begin
         n_err++; $display("FAIL b2b_first RD1=%h RD2=%h want aaaaaaaa", RD1, RD2);
      end
      @(negedge clk); ALURes = 32'h5555_5555; #1;
      n_vec++;
      if (RD2 !== 32'h5555_5555) begin n_err++; $display("FAIL b2b_second RD2=%h want 55555555", RD2); end
      n_vec++;
      if (DBG_DATA !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL b2b_dbg_old got %h want aaaaaaaa", DBG_DATA); end
      @(negedge clk); RegWrite = 0; #1;
      n_vec++;
      if (DBG_DATA !== 32'h5555_5555 || RD2 !== 32'h5555_5555) begin
         n_err++; $display("FAIL b2b_stored DBG=%h RD2=%h want 55555555", DBG_DATA, RD2);
      end
      n_vec++;
      if (WB_Count !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", WB_Count); end
   endtask

   task automatic test_reset_priority;
      @(negedge clk); RegWrite = 1; MemToReg = 0; ALURes = 32'h11; WREG = 3;
      @(negedge clk); rst = 1; ALURes = 32'hFF; RR1 = 3; DBG_ADDR = 3; #1;
      n_vec++;
      if (RD1 !== 32'h11) begin n_err++; $display("FAIL rst_no_bypass RD1=%h want 00000011", RD1); end
      @(negedge clk); #1;
      n_vec++;
      if (RD1 !== 0 || DBG_DATA !== 0) begin n_err++; $display("FAIL rst_hold RD1=%h DBG=%h want 0", RD1, DBG_DATA); end
      @(negedge clk); rst = 0; RegWrite = 0; RR2 = 7; #1;
      n_vec++;
      if (RD1 !== 0 || RD2 !== 0 || DBG_DATA !== 0) begin
         n_err++; $display("FAIL rst_cleared RD1=%h RD2=%h DBG=%h want 0", RD1, RD2, DBG_DATA);
      end
      n_vec++;
      if (WB_Count !== 0) begin n_err++; $display("FAIL rst_count got %0d want 0", WB_Count); end
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0; RegWrite = 1; #1;
      n_vec++;
      if (RD1 !== 32'hFF) begin n_err++; $display("FAIL deassert_bypass RD1=%h want 000000ff", RD1); end
      @(negedge clk); RegWrite = 0; #1;
      n_vec++;
      if (DBG_DATA !== 32'hFF || WB_Count !== 1) begin
         n_err++; $display("FAIL deassert_commit DBG=%h cnt=%0d want 000000ff/1", DBG_DATA, WB_Count);
      end
   endtask

   task automatic test_count_wrap;
      @(negedge clk); force dut.r_count = 32'hFFFF_FFFF;
      #1 release dut.r_count;
      RegWrite = 1; MemToReg = 1; MemRes = 32'h00C0_FFEE; WREG = 1; DBG_ADDR = 1;
      @(negedge clk); RegWrite = 0; #1;
      n_vec++;
      if (WB_Count !== 0) begin n_err++; $display("FAIL count_wrap got %h want 00000000", WB_Count); end
      n_vec++;
      if (DBG_DATA !== 32'h00C0_FFEE) begin n_err++; $display("FAIL wrap_write got %h want 00c0ffee", DBG_DATA); end
   endtask

   initial begin
      test_reset;
      test_bypass;
      test_reg_zero;
      test_back_to_back;
      test_reset_priority;
      test_count_wrap;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
